// File: rtl/axi_rd_arbiter_pkg.sv
// axi_rd_arbiter_pkg: shared FSM state and read-type encodings for the AXI read arbiter
//   state_t    : IDLE (free), REQ (request presented to bridge), WAIT (collecting return beats)
//   rd_type_t  : request size codes carried on the rd_type buses
//   onehot2()  : maps a port index to a one-hot 2-bit grant
package axi_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RD_WORD    = 2'b00,
        RD_LINE128 = 2'b01,
        RD_LINE256 = 2'b10
    } rd_type_t;

    localparam int NUM_PORTS = 2;

    function automatic logic [NUM_PORTS-1:0] onehot2(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// axi_rd_arbiter_rr_arb2: two-way arbiter, round-robin or fixed priority (port 1 wins)
//   clk, resetn : clock and asynchronous active-low reset
//   req[1:0]    : requests from port 0 (icache) and port 1 (dcache)
//   mode        : 0 = round-robin, 1 = fixed priority to port 1
//   upd, last   : on upd the pointer moves to favour the port that was not 'last'
//   grant[1:0]  : one-hot grant, zero when nobody requests
module axi_rd_arbiter_rr_arb2
    import axi_rd_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       mode,
    input  logic       upd,
    input  logic       last,
    output logic [1:0] grant
);

    // 0 favours port 0, 1 favours port 1
    logic ptr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            ptr <= 1'b0;
        else if (upd)
            ptr <= ~last;
    end

    // Ties resolved by pointer (or forced to port 1); a lone requester always wins
    always_comb
        grant = (&req) ? onehot2(mode | ptr) : req;

endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI read request/return channel between icache (m0) and dcache (m1)
//   clk, resetn                    : clock and asynchronous active-low reset
//   mN_rd_req/type/addr            : read request from port N, held until mN_rd_rdy
//   mN_rd_rdy                      : request of port N accepted this cycle (combinational)
//   mN_ret_valid/half/data         : return beat for port N; half=1 intermediate, 0 final
//   axi_rd_req/type/addr           : request toward the bridge, fields latched at grant
//   axi_rd_rdy                     : bridge accepts the pending request
//   axi_ret_valid/half/data        : return beats from the bridge
//   arb_err                        : sticky, a return beat arrived with no transaction waiting
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 256,
    parameter int ARB_MODE = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m0_rd_req,
    input  logic [1:0]        m0_rd_type,
    input  logic [ADDR_W-1:0] m0_rd_addr,
    output logic              m0_rd_rdy,
    output logic              m0_ret_valid,
    output logic              m0_ret_half,
    output logic [DATA_W-1:0] m0_ret_data,
    input  logic              m1_rd_req,
    input  logic [1:0]        m1_rd_type,
    input  logic [ADDR_W-1:0] m1_rd_addr,
    output logic              m1_rd_rdy,
    output logic              m1_ret_valid,
    output logic              m1_ret_half,
    output logic [DATA_W-1:0] m1_ret_data,
    output logic              axi_rd_req,
    output logic [1:0]        axi_rd_type,
    output logic [ADDR_W-1:0] axi_rd_addr,
    input  logic              axi_rd_rdy,
    input  logic              axi_ret_valid,
    input  logic              axi_ret_half,
    input  logic [DATA_W-1:0] axi_ret_data,
    output logic              arb_err
);

    state_t     state;
    logic       owner;
    logic [1:0] grant;
    logic       fin;

    assign fin = (state == ST_WAIT) && axi_ret_valid && !axi_ret_half;

    axi_rd_arbiter_rr_arb2 u_arb (
        .clk    (clk),
        .resetn (resetn),
        .req    ({m1_rd_req, m0_rd_req}),
        .mode   (ARB_MODE != 0),
        .upd    (fin),
        .last   (owner),
        .grant  (grant)
    );

    // Accept handshakes and return steering; rdy is masked during reset so every output reads 0
    always_comb begin
        m0_rd_rdy    = resetn && (state == ST_IDLE) && grant[0];
        m1_rd_rdy    = resetn && (state == ST_IDLE) && grant[1];
        m0_ret_valid = (state == ST_WAIT) && axi_ret_valid && !owner;
        m1_ret_valid = (state == ST_WAIT) && axi_ret_valid && owner;
        m0_ret_half  = m0_ret_valid && axi_ret_half;
        m1_ret_half  = m1_ret_valid && axi_ret_half;
        m0_ret_data  = axi_ret_data;
        m1_ret_data  = axi_ret_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            owner       <= 1'b0;
            axi_rd_req  <= 1'b0;
            axi_rd_type <= 2'b00;
            axi_rd_addr <= '0;
            arb_err     <= 1'b0;
        end else begin
            if (axi_ret_valid && state != ST_WAIT)
                arb_err <= 1'b1;
            case (state)
                ST_IDLE: if (|grant) begin
                    owner       <= grant[1];
                    axi_rd_type <= grant[1] ? m1_rd_type : m0_rd_type;
                    axi_rd_addr <= grant[1] ? m1_rd_addr : m0_rd_addr;
                    axi_rd_req  <= 1'b1;
                    state       <= ST_REQ;
                end
                ST_REQ: if (axi_rd_rdy) begin
                    axi_rd_req <= 1'b0;
                    state      <= ST_WAIT;
                end
                ST_WAIT: if (fin)
                    state <= ST_IDLE;
                default: begin
                    axi_rd_req <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: self-checking bench for axi_rd_arbiter, round-robin and fixed-priority instances
module tb_axi_rd_arbiter;

    localparam int AW = 32;
    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          req0 = 0, req1 = 0;
    logic [1:0]    type0 = 0, type1 = 0;
    logic [AW-1:0] addr0 = 0, addr1 = 0;
    logic          axi_rdy = 0, rv = 0, rh = 0;
    logic [DW-1:0] rd = '0;

    logic          rdy0, rv0, rh0, rdy1, rv1, rh1, areq, err;
    logic [1:0]    atype;
    logic [AW-1:0] aaddr;
    logic [DW-1:0] rd0, rd1;

    logic          b_rdy0, b_rv0, b_rh0, b_rdy1, b_rv1, b_rh1, b_areq, b_err;
    logic [1:0]    b_atype;
    logic [AW-1:0] b_aaddr;
    logic [DW-1:0] b_rd0, b_rd1;

    int checks = 0;
    int errors = 0;
    int cnt0, cnt1;
    logic [7:0] h0, h1;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0)) dut (
        .clk(clk), .resetn(resetn),
        .m0_rd_req(req0), .m0_rd_type(type0), .m0_rd_addr(addr0), .m0_rd_rdy(rdy0),
        .m0_ret_valid(rv0), .m0_ret_half(rh0), .m0_ret_data(rd0),
        .m1_rd_req(req1), .m1_rd_type(type1), .m1_rd_addr(addr1), .m1_rd_rdy(rdy1),
        .m1_ret_valid(rv1), .m1_ret_half(rh1), .m1_ret_data(rd1),
        .axi_rd_req(areq), .axi_rd_type(atype), .axi_rd_addr(aaddr), .axi_rd_rdy(axi_rdy),
        .axi_ret_valid(rv), .axi_ret_half(rh), .axi_ret_data(rd), .arb_err(err)
    );

    axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1)) dut_fp (
        .clk(clk), .resetn(resetn),
        .m0_rd_req(req0), .m0_rd_type(type0), .m0_rd_addr(addr0), .m0_rd_rdy(b_rdy0),
        .m0_ret_valid(b_rv0), .m0_ret_half(b_rh0), .m0_ret_data(b_rd0),
        .m1_rd_req(req1), .m1_rd_type(type1), .m1_rd_addr(addr1), .m1_rd_rdy(b_rdy1),
        .m1_ret_valid(b_rv1), .m1_ret_half(b_rh1), .m1_ret_data(b_rd1),
        .axi_rd_req(b_areq), .axi_rd_type(b_atype), .axi_rd_addr(b_aaddr), .axi_rd_rdy(axi_rdy),
        .axi_ret_valid(rv), .axi_ret_half(rh), .axi_ret_data(rd), .arb_err(b_err)
    );

    task automatic do_reset();
        resetn = 0; req0 = 0; req1 = 0; axi_rdy = 0; rv = 0; rh = 0; rd = '0;
        repeat (2) @(posedge clk);
        #1 resetn = 1;
    endtask

    // Bridge behaviour: called at the first REQ cycle's negedge; waits d extra cycles,
    // accepts, then returns n beats, tallying what each port receives
    task automatic bridge(input int d, input int n);
        cnt0 = 0; cnt1 = 0; h0 = '0; h1 = '0;
        repeat (d) @(posedge clk);
        @(posedge clk); #1 axi_rdy = 1;
        @(posedge clk); #1 axi_rdy = 0;
        for (int i = 0; i < n; i++) begin
            rv = 1; rh = (i != n - 1); rd = {8{$urandom}};
            @(negedge clk);
            cnt0 += int'(rv0); cnt1 += int'(rv1);
            if (rv0) h0 = {h0[6:0], rh0};
            if (rv1) h1 = {h1[6:0], rh1};
            @(posedge clk); #1;
        end
        rv = 0; rh = 0;
    endtask

    task automatic test_reset();
        logic [41:0] o, ob;
        #2 resetn = 0;
        @(negedge clk);
        o  = {rdy0, rdy1, areq, rv0, rv1, rh0, rh1, err, atype, aaddr};
        ob = {b_rdy0, b_rdy1, b_areq, b_rv0, b_rv1, b_rh0, b_rh1, b_err, b_atype, b_aaddr};
        checks++; if (o !== '0) begin errors++; $display("FAIL reset_outs got %h exp 0", o); end
        checks++; if (ob !== '0) begin errors++; $display("FAIL reset_outs_fp got %h exp 0", ob); end
        repeat (2) @(posedge clk);
        #1 resetn = 1;
        @(negedge clk);
        o = {rdy0, rdy1, areq, rv0, rv1, rh0, rh1, err, atype, aaddr};
        checks++; if (o !== '0) begin errors++; $display("FAIL post_reset_idle got %h exp 0", o); end
    endtask

    task automatic test_single_m0();
        do_reset();
        req0 = 1; type0 = 2'b10; addr0 = 32'h1FC0_0000;
        @(negedge clk);
        checks++; if ({rdy1, rdy0, areq} !== 3'b010) begin errors++; $display("FAIL single_grant got %b exp 010", {rdy1, rdy0, areq}); end
        @(posedge clk); #1 req0 = 0;
        @(negedge clk);
        checks++; if ({areq, atype, aaddr} !== {1'b1, 2'b10, 32'h1FC0_0000}) begin errors++; $display("FAIL single_req got %b %b %h exp 1 10 1fc00000", areq, atype, aaddr); end
        bridge(3, 2);
        checks++; if (cnt0 !== 2 || cnt1 !== 0) begin errors++; $display("FAIL single_beats got m0=%0d m1=%0d exp 2 0", cnt0, cnt1); end
        checks++; if (h0 !== 8'b10) begin errors++; $display("FAIL single_half got %b exp 00000010", h0); end
        @(negedge clk);
        checks++; if ({areq, rv0, rv1} !== 3'b000) begin errors++; $display("FAIL single_idle got %b exp 000", {areq, rv0, rv1}); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        req0 = 1; req1 = 1; addr0 = 32'h0000_0100; addr1 = 32'h0000_0200; type0 = 2'b01; type1 = 2'b00;
        @(negedge clk);
        checks++; if ({rdy1, rdy0} !== 2'b01) begin errors++; $display("FAIL tie_first got %b exp 01", {rdy1, rdy0}); end
        @(posedge clk); #1 req0 = 0;
        @(negedge clk);
        checks++; if ({rdy1, aaddr} !== {1'b0, 32'h0000_0100}) begin errors++; $display("FAIL tie_busy got %b %h exp 0 00000100", rdy1, aaddr); end
        bridge(1, 2);
        @(negedge clk);
        checks++; if ({rdy1, rdy0} !== 2'b10) begin errors++; $display("FAIL tie_second got %b exp 10", {rdy1, rdy0}); end
        @(posedge clk); #1 req1 = 0;
        @(negedge clk);
        checks++; if ({areq, atype, aaddr} !== {1'b1, 2'b00, 32'h0000_0200}) begin errors++; $display("FAIL tie_second_req got %b %b %h exp 1 00 00000200", areq, atype, aaddr); end
        bridge(0, 1);
        checks++; if (cnt0 !== 0 || cnt1 !== 1 || h1 !== 8'b0) begin errors++; $display("FAIL tie_second_beats got m0=%0d m1=%0d h=%b exp 0 1 0", cnt0, cnt1, h1); end
    endtask

    task automatic test_mode();
        logic fav;
        logic [1:0] e0;
        do_reset();
        fav = 0;
        req0 = 1; req1 = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            e0 = fav ? 2'b10 : 2'b01;
            fav = ~e0[1];
            checks++; if ({rdy1, rdy0} !== e0) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", k, {rdy1, rdy0}, e0); end
            checks++; if ({b_rdy1, b_rdy0} !== 2'b10) begin errors++; $display("FAIL fp_grant%0d got %b exp 10", k, {b_rdy1, b_rdy0}); end
            @(posedge clk); #1;
            @(negedge clk);
            bridge(0, 1);
        end
        req0 = 0; req1 = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_hold();
        do_reset();
        req0 = 1; type0 = 2'b01; addr0 = 32'hA5A5_0040;
        @(negedge clk);
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL hold_grant got %b exp 1", rdy0); end
        @(posedge clk); #1 req0 = 0; req1 = 1;
        for (int i = 0; i < 10; i++) begin
            addr1 = $urandom; type1 = 2'($urandom_range(0, 2)); addr0 = $urandom;
            @(negedge clk);
            checks++;
            if ({areq, rdy1, atype, aaddr} !== {1'b1, 1'b0, 2'b01, 32'hA5A5_0040}) begin
                errors++; $display("FAIL hold_stable%0d got %b %b %b %h exp 1 0 01 a5a50040", i, areq, rdy1, atype, aaddr);
            end
            @(posedge clk); #1;
        end
        axi_rdy = 1;
        @(posedge clk); #1 axi_rdy = 0; req1 = 0; rv = 1; rh = 0;
        @(negedge clk);
        checks++; if ({rv0, rv1, areq} !== 3'b100) begin errors++; $display("FAIL hold_beat got %b exp 100", {rv0, rv1, areq}); end
        @(posedge clk); #1 rv = 0;
    endtask

    task automatic test_err();
        do_reset();
        rv = 1; rh = 0;
        @(negedge clk);
        checks++; if ({rv0, rv1} !== 2'b00) begin errors++; $display("FAIL err_no_valid got %b exp 00", {rv0, rv1}); end
        @(posedge clk); #1 rv = 0;
        @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", err); end
        @(posedge clk); #1 req0 = 1; addr0 = 32'h40;
        @(posedge clk); #1 req0 = 0;
        @(negedge clk);
        bridge(0, 2);
        @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err); end
        do_reset();
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", err); end
    endtask

    task automatic test_reset_wait();
        logic [41:0] o;
        do_reset();
        req0 = 1; addr0 = 32'h0000_0800; type0 = 2'b10;
        @(posedge clk); #1 req0 = 0; axi_rdy = 1;
        @(posedge clk); #1 axi_rdy = 0; rv = 1; rh = 1;
        @(negedge clk);
        checks++; if (rv0 !== 1'b1) begin errors++; $display("FAIL rstw_beat got %b exp 1", rv0); end
        #1 resetn = 0;
        #1;
        o = {rdy0, rdy1, areq, rv0, rv1, rh0, rh1, err, atype, aaddr};
        checks++; if (o !== '0) begin errors++; $display("FAIL rstw_outs got %h exp 0", o); end
        @(posedge clk); #1 rv = 0; rh = 0; resetn = 1;
        @(posedge clk); #1 req1 = 1; addr1 = 32'h0000_1000; type1 = 2'b00;
        @(negedge clk);
        checks++; if ({rdy1, rdy0} !== 2'b10) begin errors++; $display("FAIL rstw_grant got %b exp 10", {rdy1, rdy0}); end
        @(posedge clk); #1 req1 = 0;
        @(negedge clk);
        checks++; if ({areq, aaddr} !== {1'b1, 32'h0000_1000}) begin errors++; $display("FAIL rstw_req got %b %h exp 1 00001000", areq, aaddr); end
        bridge(0, 1);
        checks++; if (cnt1 !== 1 || cnt0 !== 0) begin errors++; $display("FAIL rstw_beats got m0=%0d m1=%0d exp 0 1", cnt0, cnt1); end
    endtask

    // Transaction-level model: a tie goes to the port not granted last, a lone requester wins;
    // fixed priority always prefers m1. Returns go only to the winner.
    task automatic test_random();
        logic fav, w;
        logic [1:0] r, ew, eb;
        logic [AW-1:0] ea;
        logic [1:0] et;
        int d, nb;
        do_reset();
        fav = 0;
        for (int n = 0; n < 30; n++) begin
            r = 2'($urandom_range(1, 3));
            req0 = r[0]; req1 = r[1];
            addr0 = $urandom; addr1 = $urandom;
            type0 = 2'($urandom_range(0, 2)); type1 = 2'($urandom_range(0, 2));
            w  = (&r) ? fav : r[1];
            ew = w ? 2'b10 : 2'b01;
            eb = r[1] ? 2'b10 : 2'b01;
            ea = w ? addr1 : addr0;
            et = w ? type1 : type0;
            fav = ~w;
            @(negedge clk);
            checks++; if ({rdy1, rdy0} !== ew) begin errors++; $display("FAIL rnd_grant%0d got %b exp %b", n, {rdy1, rdy0}, ew); end
            checks++; if ({b_rdy1, b_rdy0} !== eb) begin errors++; $display("FAIL rnd_fp_grant%0d got %b exp %b", n, {b_rdy1, b_rdy0}, eb); end
            @(posedge clk); #1;
            if (w) req1 = 0; else req0 = 0;
            d = $urandom_range(0, 3);
            for (int i = 0; i <= d; i++) begin
                axi_rdy = (i == d);
                addr0 = $urandom; addr1 = $urandom;
                @(negedge clk);
                checks++;
                if ({areq, rdy0, rdy1, atype, aaddr} !== {1'b1, 1'b0, 1'b0, et, ea}) begin
                    errors++; $display("FAIL rnd_req%0d got %b %b%b %b %h exp 1 00 %b %h", n, areq, rdy0, rdy1, atype, aaddr, et, ea);
                end
                @(posedge clk); #1;
            end
            axi_rdy = 0;
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 1) == 1) begin
                    rv = 0; rh = 1'($urandom);
                    @(negedge clk);
                    checks++; if ({rv1, rv0, rdy1, rdy0} !== 4'b0) begin errors++; $display("FAIL rnd_gap%0d got %b exp 0000", n, {rv1, rv0, rdy1, rdy0}); end
                    @(posedge clk); #1;
                end
                rv = 1; rh = (b != nb - 1); rd = {8{$urandom}};
                @(negedge clk);
                checks++;
                if ({rv1, rv0, rh1, rh0, rdy1, rdy0} !== {ew, w & rh, ~w & rh, 2'b00}) begin
                    errors++; $display("FAIL rnd_beat%0d got %b exp %b", n, {rv1, rv0, rh1, rh0, rdy1, rdy0}, {ew, w & rh, ~w & rh, 2'b00});
                end
                checks++; if (rd0 !== rd || rd1 !== rd) begin errors++; $display("FAIL rnd_data%0d got %h exp %h", n, rd0, rd); end
                @(posedge clk); #1;
            end
            rv = 0; rh = 0;
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rnd_err got %b exp 0", err); end
    endtask

    initial begin
        test_reset();
        test_single_m0();
        test_same_cycle();
        test_mode();
        test_hold();
        test_err();
        test_reset_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
